// File: rtl/cpu_pkg.sv
// Shared CPU constants and the F/D slot payload type.
// Exception codes, the NOP encoding and the reset/handler PCs live here.
package cpu_pkg;

    localparam logic [4:0]  EXC_NONE   = 5'd0;
    localparam logic [4:0]  EXC_ADEL   = 5'd4;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
        logic        bd;
        logic        valid;
    } fd_slot_t;

    typedef enum logic [1:0] {
        UPD_LOAD,
        UPD_HOLD,
        UPD_INT,
        UPD_ERET
    } fd_upd_e;

    // A bubble keeps only its PC; everything else is inert.
    function automatic fd_slot_t bubble_slot(input logic [31:0] pc);
        fd_slot_t s;
        s.pc    = pc;
        s.instr = NOP_INSTR;
        s.exc   = EXC_NONE;
        s.bd    = 1'b0;
        s.valid = 1'b0;
        return s;
    endfunction

    // A faulting fetch stays a valid slot but never executes its word.
    function automatic fd_slot_t fetch_slot(input logic [31:0] pc,
                                            input logic [31:0] instr,
                                            input logic [4:0]  exc,
                                            input logic        bd);
        fd_slot_t s;
        s.pc    = pc;
        s.instr = (exc == EXC_NONE) ? instr : NOP_INSTR;
        s.exc   = exc;
        s.bd    = bd;
        s.valid = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones, cleared only by reset.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] r_count;
    logic         w_full;

    assign w_full = &r_count;

    always_ff @(posedge clk) begin
        if (!reset)
            r_count <= '0;
        else if (inc && !w_full)
            r_count <= r_count + 1'b1;
    end

    assign count = r_count;

endmodule

// File: rtl/fd_reg.sv
// F/D pipeline register: captures fetch outputs, holds on stall, bubbles on
// interrupt/eret, and counts stall cycles and inserted bubbles.
module fd_reg #(
    parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC,
    parameter logic [31:0] HANDLER_PC = cpu_pkg::HANDLER_PC,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             D_Enable,
    input  logic             IntReq,
    input  logic             D_eret,
    input  logic [31:0]      F_PC,
    input  logic [31:0]      F_Instr,
    input  logic [4:0]       F_ExcCode,
    input  logic             F_BD,
    output logic [31:0]      D_PC,
    output logic [31:0]      D_Instr,
    output logic [4:0]       D_ExcCode,
    output logic             D_BD,
    output logic             D_Valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);
    import cpu_pkg::*;

    fd_slot_t r_d;
    fd_upd_e  w_upd;
    logic     w_stall_inc;
    logic     w_bubble_inc;

    // IntReq outranks a stall so a flush is never lost behind a held slot.
    always_comb begin
        w_upd = UPD_LOAD;
        if (IntReq)
            w_upd = UPD_INT;
        else if (!D_Enable)
            w_upd = UPD_HOLD;
        else if (D_eret)
            w_upd = UPD_ERET;
    end

    assign w_stall_inc  = (w_upd == UPD_HOLD);
    assign w_bubble_inc = (w_upd == UPD_INT) || (w_upd == UPD_ERET);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_d <= bubble_slot(RESET_PC);
        end else begin
            case (w_upd)
                UPD_INT:  r_d <= bubble_slot(HANDLER_PC);
                UPD_HOLD: r_d <= r_d;
                UPD_ERET: r_d <= bubble_slot(F_PC);
                default:  r_d <= fetch_slot(F_PC, F_Instr, F_ExcCode, F_BD);
            endcase
        end
    end

    assign D_PC      = r_d.pc;
    assign D_Instr   = r_d.instr;
    assign D_ExcCode = r_d.exc;
    assign D_BD      = r_d.bd;
    assign D_Valid   = r_d.valid;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_bubble_inc),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_fd_reg.sv
// Self-checking bench for fd_reg: directed scenarios then random traffic
// against a behavioural model; a second instance uses 2-bit counters.
module tb_fd_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        D_Enable = 1'b0;
    logic        IntReq = 1'b0;
    logic        D_eret = 1'b0;
    logic [31:0] F_PC = 32'h0;
    logic [31:0] F_Instr = 32'h0;
    logic [4:0]  F_ExcCode = 5'd0;
    logic        F_BD = 1'b0;

    logic [31:0] D_PC, D_Instr, stall_cnt, bubble_cnt;
    logic [4:0]  D_ExcCode;
    logic        D_BD, D_Valid;

    logic [31:0] s_PC, s_Instr;
    logic [4:0]  s_ExcCode;
    logic        s_BD, s_Valid;
    logic [1:0]  s_stall_cnt, s_bubble_cnt;

    fd_reg dut (
        .clk(clk), .reset(reset), .D_Enable(D_Enable), .IntReq(IntReq),
        .D_eret(D_eret), .F_PC(F_PC), .F_Instr(F_Instr), .F_ExcCode(F_ExcCode),
        .F_BD(F_BD), .D_PC(D_PC), .D_Instr(D_Instr), .D_ExcCode(D_ExcCode),
        .D_BD(D_BD), .D_Valid(D_Valid), .stall_cnt(stall_cnt),
        .bubble_cnt(bubble_cnt)
    );

    fd_reg #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .D_Enable(D_Enable), .IntReq(IntReq),
        .D_eret(D_eret), .F_PC(F_PC), .F_Instr(F_Instr), .F_ExcCode(F_ExcCode),
        .F_BD(F_BD), .D_PC(s_PC), .D_Instr(s_Instr), .D_ExcCode(s_ExcCode),
        .D_BD(s_BD), .D_Valid(s_Valid), .stall_cnt(s_stall_cnt),
        .bubble_cnt(s_bubble_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc, m_instr;
    logic [4:0]  m_exc;
    logic        m_bd, m_valid;
    longint      m_stall, m_bub, m_stall2, m_bub2;

    function automatic longint sat_inc(input longint v, input int w);
        longint top;
        top = (64'sd1 <<< w) - 1;
        return (v >= top) ? top : v + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // What D should hold after this edge, given the inputs present at it.
    task automatic model_edge();
        if (!reset) begin
            m_pc = 32'h3000; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
            m_stall = 0; m_bub = 0; m_stall2 = 0; m_bub2 = 0;
        end else if (IntReq) begin
            m_pc = 32'h4180; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
            m_bub = sat_inc(m_bub, 32); m_bub2 = sat_inc(m_bub2, 2);
        end else if (!D_Enable) begin
            m_stall = sat_inc(m_stall, 32); m_stall2 = sat_inc(m_stall2, 2);
        end else if (D_eret) begin
            m_pc = F_PC; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
            m_bub = sat_inc(m_bub, 32); m_bub2 = sat_inc(m_bub2, 2);
        end else begin
            m_pc = F_PC; m_exc = F_ExcCode; m_bd = F_BD; m_valid = 1;
            m_instr = (F_ExcCode == 0) ? F_Instr : 32'h0;
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".pc"},      D_PC,                 m_pc);
        chk({tag, ".instr"},   D_Instr,              m_instr);
        chk({tag, ".exc"},     32'(D_ExcCode),       32'(m_exc));
        chk({tag, ".bd"},      32'(D_BD),            32'(m_bd));
        chk({tag, ".valid"},   32'(D_Valid),         32'(m_valid));
        chk({tag, ".stall"},   stall_cnt,            32'(m_stall));
        chk({tag, ".bubble"},  bubble_cnt,           32'(m_bub));
        chk({tag, ".s_pc"},    s_PC,                 m_pc);
        chk({tag, ".s_stall"}, 32'(s_stall_cnt),     32'(m_stall2));
        chk({tag, ".s_bub"},   32'(s_bubble_cnt),    32'(m_bub2));
    endtask

    task automatic drive(input logic en, input logic irq, input logic er,
                         input logic [31:0] pc, input logic [31:0] ins,
                         input logic [4:0] exc, input logic bd);
        D_Enable = en; IntReq = irq; D_eret = er;
        F_PC = pc; F_Instr = ins; F_ExcCode = exc; F_BD = bd;
    endtask

    initial begin
        // reset held for two cycles
        reset = 1'b0;
        drive(1, 0, 0, 32'h3004, 32'h3c01_1234, 0, 0);
        step("reset0");
        step("reset1");
        chk("reset_pc", D_PC, 32'h0000_3000);
        chk("reset_valid", 32'(D_Valid), 32'd0);
        reset = 1'b1;

        step("normal");
        chk("normal_instr", D_Instr, 32'h3c01_1234);

        drive(1, 0, 0, 32'h3008, 32'h2002_0001, 0, 0);
        step("load3008");
        drive(0, 0, 0, 32'h300c, 32'h2002_0002, 0, 0);
        step("stall1");
        step("stall2");
        step("stall3");
        chk("stall_hold_pc", D_PC, 32'h0000_3008);
        chk("stall_cnt3", stall_cnt, 32'd3);

        drive(1, 0, 0, 32'h3001, 32'hffff_ffff, 5'd4, 0);
        step("fault");
        chk("fault_instr", D_Instr, 32'h0);
        chk("fault_exc", 32'(D_ExcCode), 32'd4);
        chk("fault_valid", 32'(D_Valid), 32'd1);

        drive(0, 1, 0, 32'h3014, 32'h1234_5678, 0, 1);
        step("int_stall");
        chk("int_pc", D_PC, 32'h0000_4180);
        chk("int_bub", bubble_cnt, 32'd1);
        chk("int_nostall", stall_cnt, 32'd3);

        drive(1, 0, 1, 32'h3010, 32'h0000_0008, 0, 1);
        step("eret");
        chk("eret_pc", D_PC, 32'h0000_3010);
        chk("eret_bub", bubble_cnt, 32'd2);

        // fresh reset, then five eret bubbles saturate the 2-bit counter
        reset = 1'b0;
        step("reset2");
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, 32'h3100 + 32'(i * 4), 32'hdead_beef, 0, 0);
            step("eret_sat");
        end
        chk("sat_small", 32'(s_bubble_cnt), 32'd3);
        chk("sat_big", bubble_cnt, 32'd5);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [4:0] exc;
            exc = ($urandom_range(0, 4) == 0) ? 5'(($urandom_range(0, 1) != 0) ? 4 : $urandom_range(1, 31)) : 5'd0;
            reset = ($urandom_range(0, 49) != 0);
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 6) == 0, {$urandom()} & 32'hffff_fffc,
                  $urandom(), exc, 1'($urandom_range(0, 1)));
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
